// File: rtl/aes_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// aes_ctrl_pkg
//   Shared types for the iterative AES decryption sequencer.
//   op_t    : datapath operation selected in a given cycle.
//   state_t : sequencer FSM states.
//   AES_MAX_ROUNDS / RND_W : sizing for the round counter and key index,
//   wide enough for AES-256 (14 rounds) whatever NUM_ROUNDS is chosen.
// ----------------------------------------------------------------------------
package aes_ctrl_pkg;

  localparam int unsigned AES_MAX_ROUNDS = 14;
  localparam int unsigned RND_W          = $clog2(AES_MAX_ROUNDS + 1);

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_ARK  = 3'd1,
    OP_ISR  = 3'd2,
    OP_ISB  = 3'd3,
    OP_IMC  = 3'd4
  } op_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_KEY_WAIT,
    ST_ARK0,
    ST_ISR,
    ST_ISB,
    ST_ARK,
    ST_IMC,
    ST_DONE,
    ST_ERR
  } state_t;

  // Busy covers every state in which a run is in progress; IDLE, DONE and
  // ERR are the resting states.
  function automatic logic is_busy(input state_t s);
    return !(s inside {ST_IDLE, ST_DONE, ST_ERR});
  endfunction

endpackage

// File: rtl/aes_ctrl_cnt.sv
// ----------------------------------------------------------------------------
// aes_ctrl_cnt
//   Round and column counters for the AES decryption sequencer.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     load        : rnd <- NUM_ROUNDS-1 (entering the first inverse round)
//     dec_rnd     : rnd <- rnd-1, saturating at 0
//     inc_col     : col <- col+1 (2-bit, wraps 3->0)
//     clr_col     : col <- 0 (has priority over inc_col)
//     rnd, col    : current counter values
//     last_rnd    : rnd == 0
//     last_col    : col == 3
// ----------------------------------------------------------------------------
module aes_ctrl_cnt
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec_rnd,
  input  logic             inc_col,
  input  logic             clr_col,
  output logic [RND_W-1:0] rnd,
  output logic [1:0]       col,
  output logic             last_rnd,
  output logic             last_col
);

  logic [RND_W-1:0] rnd_d, rnd_q;
  logic [1:0]       col_d, col_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    rnd_d = rnd_q;
    col_d = col_q;
    if (load) begin
      rnd_d = RND_W'(NUM_ROUNDS - 1);
    end else if (dec_rnd && (rnd_q != '0)) begin
      rnd_d = rnd_q - 1'b1;
    end
    if (clr_col) begin
      col_d = '0;
    end else if (inc_col) begin
      col_d = col_q + 2'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge value regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd_q <= '0;
      col_q <= '0;
    end else begin
      rnd_q <= rnd_d;
      col_q <= col_d;
    end
  end

  assign rnd      = rnd_q;
  assign col      = col_q;
  assign last_rnd = (rnd_q == '0);
  assign last_col = (col_q == 2'd3);

endmodule

// File: rtl/aes_dec_ctrl.sv
// ----------------------------------------------------------------------------
// aes_dec_ctrl
//   Sequencer for the iterative AES decryption datapath. Loads the ciphertext,
//   kicks the key expansion, waits for the key schedule, then issues one
//   datapath op per cycle: ARK(Nr), then per round ISR, ISB, ARK(r), IMC x4
//   (one column per cycle), finishing with ISR, ISB, ARK(0).
//   All outputs are decodes of the registered state (Moore).
//
//   Ports:
//     Clk        : clock, all state on the rising edge
//     Reset      : asynchronous active-low reset
//     start      : level-sensitive run request; dropping it aborts a run
//     key_ready  : key schedule valid, sampled in KEY_WAIT
//     key_start  : 1-cycle pulse starting key expansion
//     msg_ld     : state register <- ciphertext
//     state_ld   : state register <- datapath result
//     op_sel     : datapath operation (op_t)
//     key_idx    : round key index for OP_ARK
//     col_idx    : column for OP_IMC
//     busy       : run in progress
//     done       : run complete, held until start drops
//     err        : key-wait timeout
//
//   Optional feature macro: AES_DEC_CTRL_TIMEOUT_EN
//     Defined   : KEY_WAIT gives up after KEY_TIMEOUT cycles -> ERR (err=1).
//     Undefined : KEY_WAIT waits indefinitely; err is tied low.
// ----------------------------------------------------------------------------
module aes_dec_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS  = 10,
  parameter int unsigned KEY_TIMEOUT = 64
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       start,
  input  logic       key_ready,
  output logic       key_start,
  output logic       msg_ld,
  output logic       state_ld,
  output op_t        op_sel,
  output logic [3:0] key_idx,
  output logic [1:0] col_idx,
  output logic       busy,
  output logic       done,
  output logic       err
);

  state_t state_d, state_q;

  logic             cnt_load, cnt_dec_rnd, cnt_inc_col, cnt_clr_col;
  logic [RND_W-1:0] rnd;
  logic [1:0]       col;
  logic             last_rnd, last_col;
  logic             timeout_hit;

  aes_ctrl_cnt #(
    .NUM_ROUNDS (NUM_ROUNDS)
  ) u_cnt (
    .clk      (Clk),
    .rst_n    (Reset),
    .load     (cnt_load),
    .dec_rnd  (cnt_dec_rnd),
    .inc_col  (cnt_inc_col),
    .clr_col  (cnt_clr_col),
    .rnd      (rnd),
    .col      (col),
    .last_rnd (last_rnd),
    .last_col (last_col)
  );

`ifdef AES_DEC_CTRL_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(KEY_TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt_d, to_cnt_q;

  // Counts consecutive KEY_WAIT cycles without key_ready; cleared elsewhere.
  always_comb begin
    to_cnt_d = '0;
    if ((state_q == ST_KEY_WAIT) && !key_ready) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  // Last allowed waiting cycle: the KEY_TIMEOUT-th cycle spent in KEY_WAIT.
  assign timeout_hit = !key_ready && (to_cnt_q == TO_W'(KEY_TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and counter control.
  always_comb begin
    state_d     = state_q;
    cnt_load    = 1'b0;
    cnt_dec_rnd = 1'b0;
    cnt_inc_col = 1'b0;
    cnt_clr_col = 1'b0;

    // Dropping start aborts any run in progress; counters are left alone
    // because ARK0 and ARK reload them before they are used again.
    if (is_busy(state_q) && !start) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:     if (start) state_d = ST_LOAD;
        ST_LOAD:     state_d = ST_KEY_WAIT;
        ST_KEY_WAIT: begin
          if (key_ready) begin
            state_d = ST_ARK0;
          end else if (timeout_hit) begin
            state_d = ST_ERR;
          end
        end
        ST_ARK0: begin
          cnt_load = 1'b1;
          state_d  = ST_ISR;
        end
        ST_ISR:      state_d = ST_ISB;
        ST_ISB:      state_d = ST_ARK;
        ST_ARK: begin
          if (last_rnd) begin
            state_d = ST_DONE;
          end else begin
            cnt_clr_col = 1'b1;
            state_d     = ST_IMC;
          end
        end
        ST_IMC: begin
          cnt_inc_col = 1'b1;
          if (last_col) begin
            cnt_dec_rnd = 1'b1;
            state_d     = ST_ISR;
          end
        end
        // DONE and ERR are left only by dropping start, which also forces
        // the restart to see a fresh 0->1 on start.
        ST_DONE:     if (!start) state_d = ST_IDLE;
        ST_ERR:      if (!start) state_d = ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: only the control state and counters are reset; the state register
  // contents live in the datapath and are overwritten by msg_ld on every run.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Moore output decode.
  always_comb begin
    key_start = 1'b0;
    msg_ld    = 1'b0;
    state_ld  = 1'b0;
    op_sel    = OP_NONE;
    key_idx   = '0;
    col_idx   = '0;
    busy      = is_busy(state_q);
    done      = (state_q == ST_DONE);
    err       = 1'b0;

    unique case (state_q)
      ST_LOAD: begin
        msg_ld    = 1'b1;
        key_start = 1'b1;
      end
      ST_ARK0: begin
        op_sel   = OP_ARK;
        key_idx  = RND_W'(NUM_ROUNDS);
        state_ld = 1'b1;
      end
      ST_ISR: begin
        op_sel   = OP_ISR;
        state_ld = 1'b1;
      end
      ST_ISB: begin
        op_sel   = OP_ISB;
        state_ld = 1'b1;
      end
      ST_ARK: begin
        op_sel   = OP_ARK;
        key_idx  = rnd;
        state_ld = 1'b1;
      end
      ST_IMC: begin
        op_sel   = OP_IMC;
        col_idx  = col;
        state_ld = 1'b1;
      end
      ST_ERR: begin
`ifdef AES_DEC_CTRL_TIMEOUT_EN
        err = 1'b1;
`else
        err = 1'b0;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes_dec_ctrl.sv
// ----------------------------------------------------------------------------
// tb_aes_dec_ctrl
//   Self-checking bench for aes_dec_ctrl. A behavioural AES-128 datapath and
//   key schedule sit around the sequencer and obey its control outputs; the
//   result is compared against FIPS-197 C.1 and against a whole-state
//   reference decryption of random key/ciphertext pairs.
//   Inputs are driven and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_aes_dec_ctrl;
  import aes_ctrl_pkg::*;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam int           NR     = 10;
  localparam int           WORK   = 1 + (NR - 1) * 7 + 3;  // 67 op cycles

  logic       Clk, Reset, start, key_ready;
  logic       key_start, msg_ld, state_ld, busy, done, err;
  op_t        op_sel;
  logic [3:0] key_idx;
  logic [1:0] col_idx;

  int errors = 0;
  int checks = 0;

  logic [7:0]   sbox_t     [256];
  logic [7:0]   inv_sbox_t [256];
  logic [127:0] rk         [15];
  logic [127:0] ct_in;
  logic [127:0] dp_state;
  int           n_state_ld  = 0;
  int           n_key_start = 0;
  logic [8:0]   trace_q [$];

  aes_dec_ctrl #(.NUM_ROUNDS(NR), .KEY_TIMEOUT(64)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .start     (start),
    .key_ready (key_ready),
    .key_start (key_start),
    .msg_ld    (msg_ld),
    .state_ld  (state_ld),
    .op_sel    (op_sel),
    .key_idx   (key_idx),
    .col_idx   (col_idx),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- AES arithmetic ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    for (int i = 0; i < 256; i++) begin
      inv = 8'h00;
      if (i != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gf_mul(inv, 8'(i));
      end
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox_t[i]     = s;
      inv_sbox_t[s] = 8'(i);
    end
  endtask

  function automatic logic [7:0] get_b(input logic [127:0] s, input int n);
    return s[127-8*n -: 8];
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = get_b(s, 4 * ((c - r + 4) % 4) + r);
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int n = 0; n < 16; n++) o[127-8*n -: 8] = inv_sbox_t[get_b(s, n)];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_col(input logic [127:0] s, input int c);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o  = s;
    a0 = get_b(s, 4*c);   a1 = get_b(s, 4*c+1);
    a2 = get_b(s, 4*c+2); a3 = get_b(s, 4*c+3);
    o[127-8*(4*c)   -: 8] = gf_mul(a0,8'h0e)^gf_mul(a1,8'h0b)^gf_mul(a2,8'h0d)^gf_mul(a3,8'h09);
    o[127-8*(4*c+1) -: 8] = gf_mul(a0,8'h09)^gf_mul(a1,8'h0e)^gf_mul(a2,8'h0b)^gf_mul(a3,8'h0d);
    o[127-8*(4*c+2) -: 8] = gf_mul(a0,8'h0d)^gf_mul(a1,8'h09)^gf_mul(a2,8'h0e)^gf_mul(a3,8'h0b);
    o[127-8*(4*c+3) -: 8] = gf_mul(a0,8'h0b)^gf_mul(a1,8'h0d)^gf_mul(a2,8'h09)^gf_mul(a3,8'h0e);
    return o;
  endfunction

  task automatic key_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rcon, 24'h0};
        rcon = gf_mul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Textbook inverse cipher on the whole state.
  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
    logic [127:0] s;
    s = ct ^ rk[NR];
    for (int r = NR - 1; r >= 1; r--) begin
      s = inv_sub_bytes(inv_shift_rows(s)) ^ rk[r];
      for (int c = 0; c < 4; c++) s = inv_mix_col(s, c);
    end
    return inv_sub_bytes(inv_shift_rows(s)) ^ rk[0];
  endfunction

  function automatic logic [127:0] apply_op(input logic [127:0] s, input op_t op,
                                            input logic [3:0] k, input logic [1:0] c);
    case (op)
      OP_ARK:  return s ^ rk[k];
      OP_ISR:  return inv_shift_rows(s);
      OP_ISB:  return inv_sub_bytes(s);
      OP_IMC:  return inv_mix_col(s, int'(c));
      default: return s;
    endcase
  endfunction

  // Behavioural datapath plus event recorder, driven by the sequencer.
  always @(posedge Clk) begin
    if (msg_ld) dp_state <= ct_in;
    else if (state_ld) dp_state <= apply_op(dp_state, op_sel, key_idx, col_idx);
    if (state_ld) begin
      n_state_ld <= n_state_ld + 1;
      trace_q.push_back({op_sel, key_idx, col_idx});
    end
    if (key_start) n_key_start <= n_key_start + 1;
  end

  function automatic logic [14:0] out_vec();
    return {key_start, msg_ld, state_ld, op_sel, key_idx, col_idx, busy, done, err};
  endfunction

  // ---------------- scenario tasks ----------------
  // One complete run. The latency counted is the number of edges from the
  // edge that samples key_ready (k) up to the one entering DONE (k+67); the
  // register file then first samples done=1 at edge k+68.
  task automatic run_op(input string name, input logic [127:0] key, input logic [127:0] ct,
                        input logic [127:0] pt, input int delay, input bit drop_start);
    int  ld0, ks0, n;
    bit  seen;
    key_expand(key);
    ct_in = ct;
    ld0   = n_state_ld;
    ks0   = n_key_start;
    start = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge Clk);
      seen = key_start;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s key_start: not seen within 8 cycles", name);
      start = 1'b0;
      return;
    end
    @(negedge Clk);  // KEY_WAIT
    checks++;
    if (!(busy && op_sel == OP_NONE && !key_start && !msg_ld && !state_ld)) begin
      errors++;
      $display("FAIL %s key_wait: outputs=%h, required busy only", name, out_vec());
    end
    if (delay > 0) begin
      key_ready = 1'b0;
      repeat (delay) @(negedge Clk);
    end
    key_ready = 1'b1;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!done && n < 200);
    key_ready = 1'b0;
    checks++;
    if (n != WORK + 1) begin
      errors++;
      $display("FAIL %s latency: edges k..DONE=%0d required %0d", name, n, WORK + 1);
    end
    checks++;
    if (dp_state !== pt) begin
      errors++;
      $display("FAIL %s plaintext: got %h required %h", name, dp_state, pt);
    end
    checks++;
    if (n_state_ld - ld0 != WORK || n_key_start - ks0 != 1) begin
      errors++;
      $display("FAIL %s counts: state_ld=%0d key_start=%0d required %0d/1",
               name, n_state_ld - ld0, n_key_start - ks0, WORK);
    end
    if (drop_start) begin
      start = 1'b0;
      @(negedge Clk);
      checks++;
      if (out_vec() !== '0) begin
        errors++;
        $display("FAIL %s idle_after_done: outputs=%h required 0", name, out_vec());
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; start = 1'b0; key_ready = 1'b0;
    #1 Reset = 1'b0;
    #1;
    checks++;
    if (out_vec() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", out_vec());
    end
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    checks++;
    if (out_vec() !== '0 || op_sel !== OP_NONE) begin
      errors++;
      $display("FAIL idle_after_reset: got %h required 0", out_vec());
    end
  endtask

  task automatic test_fips_c1();
    key_expand(C1_KEY);
    checks++;
    if (ref_decrypt(C1_CT) !== C1_PT) begin
      errors++;
      $display("FAIL ref_model_c1: got %h required %h", ref_decrypt(C1_CT), C1_PT);
    end
    run_op("fips_c1", C1_KEY, C1_CT, C1_PT, 3, 1'b1);
  endtask

  task automatic test_op_trace();
    logic [8:0] exp_q [$];
    int         base, bad;
    exp_q.push_back({OP_ARK, 4'(NR), 2'd0});
    for (int r = NR - 1; r >= 1; r--) begin
      exp_q.push_back({OP_ISR, 4'd0, 2'd0});
      exp_q.push_back({OP_ISB, 4'd0, 2'd0});
      exp_q.push_back({OP_ARK, 4'(r), 2'd0});
      for (int c = 0; c < 4; c++) exp_q.push_back({OP_IMC, 4'd0, 2'(c)});
    end
    exp_q.push_back({OP_ISR, 4'd0, 2'd0});
    exp_q.push_back({OP_ISB, 4'd0, 2'd0});
    exp_q.push_back({OP_ARK, 4'd0, 2'd0});
    base      = trace_q.size();
    key_ready = 1'b1;
    run_op("op_trace", C1_KEY, C1_CT, C1_PT, 0, 1'b1);
    checks++;
    if (trace_q.size() - base != exp_q.size()) begin
      errors++;
      $display("FAIL op_trace_len: got %0d required %0d", trace_q.size() - base, exp_q.size());
    end else begin
      bad = -1;
      for (int i = 0; i < exp_q.size() && bad < 0; i++)
        if (trace_q[base + i] !== exp_q[i]) bad = i;
      if (bad >= 0) begin
        errors++;
        $display("FAIL op_trace_step%0d: got {op,key,col}=%h required %h",
                 bad, trace_q[base + bad], exp_q[bad]);
      end
    end
  endtask

  task automatic test_random();
    logic [127:0] key, ct, pt;
    for (int t = 0; t < 4; t++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      ct  = {$urandom, $urandom, $urandom, $urandom};
      key_expand(key);
      pt  = ref_decrypt(ct);
      run_op($sformatf("random%0d", t), key, ct, pt, int'($urandom_range(0, 12)), 1'b1);
    end
  endtask

  task automatic test_abort();
    int  last_ark, ld0;
    bit  hit;
    key_expand(C1_KEY);
    ct_in     = C1_CT;
    start     = 1'b1;
    key_ready = 1'b1;
    last_ark  = -1;
    hit       = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge Clk);
      if (op_sel == OP_ARK) last_ark = int'(key_idx);
      hit = (op_sel == OP_IMC) && (last_ark == 5) && (col_idx == 2'd2);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL abort_point: IMC r=5 c=2 not reached");
    end
    start     = 1'b0;
    key_ready = 1'b0;
    @(negedge Clk);
    ld0 = n_state_ld;
    checks++;
    if (out_vec() !== '0) begin
      errors++;
      $display("FAIL abort_idle: outputs=%h required 0", out_vec());
    end
    repeat (5) @(negedge Clk);
    checks++;
    if (done !== 1'b0 || n_state_ld != ld0) begin
      errors++;
      $display("FAIL abort_quiet: done=%b extra state_ld=%0d required 0/0", done, n_state_ld - ld0);
    end
    run_op("abort_rerun", C1_KEY, C1_CT, C1_PT, 1, 1'b1);
  endtask

  task automatic test_hold();
    int ld0, ks0, low;
    run_op("hold_run", C1_KEY, C1_CT, C1_PT, 2, 1'b0);
    ld0 = n_state_ld;
    ks0 = n_key_start;
    low = 0;
    repeat (200) begin
      @(negedge Clk);
      if (done !== 1'b1 || busy !== 1'b0) low++;
    end
    checks++;
    if (low != 0 || n_state_ld != ld0 || n_key_start != ks0) begin
      errors++;
      $display("FAIL hold_done: cycles not done=%0d state_ld=%0d key_start=%0d required 0/0/0",
               low, n_state_ld - ld0, n_key_start - ks0);
    end
    start = 1'b0;
    @(negedge Clk);
    checks++;
    if (out_vec() !== '0) begin
      errors++;
      $display("FAIL hold_release: outputs=%h required 0", out_vec());
    end
    start = 1'b1;
    @(negedge Clk);
    checks++;
    if (key_start !== 1'b1 || msg_ld !== 1'b1) begin
      errors++;
      $display("FAIL hold_restart: key_start=%b msg_ld=%b required 1/1", key_start, msg_ld);
    end
    start = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_timeout();
    int bad;
    key_ready = 1'b0;
    start     = 1'b1;
    @(negedge Clk);  // LOAD
    bad = 0;
`ifdef AES_DEC_CTRL_TIMEOUT_EN
    // j = edges since the one entering KEY_WAIT; ERR follows 64 waiting cycles.
    for (int j = 0; j < 64; j++) begin
      @(negedge Clk);
      if (err !== 1'b0 || busy !== 1'b1) bad++;
    end
    @(negedge Clk);
    checks++;
    if (bad != 0 || err !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err: early=%0d err=%b busy=%b done=%b required 0/1/0/0",
               bad, err, busy, done);
    end
`else
    for (int j = 0; j < 1000; j++) begin
      @(negedge Clk);
      if (err !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || op_sel !== OP_NONE) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL key_wait_forever: %0d of 1000 cycles left KEY_WAIT", bad);
    end
`endif
    start = 1'b0;
    @(negedge Clk);
    checks++;
    if (out_vec() !== '0) begin
      errors++;
      $display("FAIL timeout_exit: outputs=%h required 0", out_vec());
    end
  endtask

  task automatic test_async_reset();
    bit hit;
    key_expand(C1_KEY);
    ct_in     = C1_CT;
    start     = 1'b1;
    key_ready = 1'b1;
    hit       = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge Clk);
      hit = (op_sel == OP_ISB);
    end
    #2 Reset = 1'b0;
    #1;
    checks++;
    if (!hit || out_vec() !== '0) begin
      errors++;
      $display("FAIL async_reset: reached_isb=%b outputs=%h required 1/0", hit, out_vec());
    end
    @(negedge Clk);
    Reset     = 1'b1;
    start     = 1'b0;
    key_ready = 1'b0;
    @(negedge Clk);
    run_op("after_reset", C1_KEY, C1_CT, C1_PT, 0, 1'b1);
  endtask

  initial begin
    start     = 1'b0;
    key_ready = 1'b0;
    Reset     = 1'b1;
    ct_in     = '0;
    build_sbox();
    test_reset();
    test_fips_c1();
    test_op_trace();
    test_random();
    test_abort();
    test_hold();
    test_timeout();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
